stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_stack_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Stack controller: top-of-stack held in a register, remaining items spilled to
// an external single-port synchronous RAM. One command in flight at a time.
module stack_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [DATA_W-1:0] top,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WB, SWR} state_e;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   top_q, top_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_error_q, rsp_error_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic [ADDR_W:0]     cnt_m1, cnt_m2;
  logic [ADDR_W-1:0]   sp, sp_below;
  logic                is_empty, is_full, lt_two;

  // sp indexes the RAM slot the current top would spill into; sp_below holds
  // the item directly under top.
  assign cnt_m1   = count_q - CNT_ONE;
  assign cnt_m2   = count_q - CNT_TWO;
  assign sp       = cnt_m1[ADDR_W-1:0];
  assign sp_below = cnt_m2[ADDR_W-1:0];
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign lt_two   = (count_q < CNT_TWO);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    top_d       = top_q;
    count_d     = count_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          rsp_valid_d = 1'b1;
          case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (is_full) begin
                rsp_error_d = 1'b1;
              end else begin
                if (!is_empty) begin
                  ram_we_d    = 1'b1;
                  ram_addr_d  = sp;
                  ram_wdata_d = top_q;
                end
                top_d   = cmd_data;
                count_d = count_q + CNT_ONE;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                rsp_error_d = 1'b1;
              end else if (count_q == CNT_ONE) begin
                top_d   = '0;
                count_d = '0;
              end else begin
                rsp_valid_d = 1'b0;
                ram_addr_d  = sp_below;
                state_d     = RD;
              end
            end
            OP_INC: begin
              if (is_empty) rsp_error_d = 1'b1;
              else          top_d = top_q + DATA_W'(1);
            end
            OP_ADD, OP_SWAP: begin
              if (lt_two) begin
                rsp_error_d = 1'b1;
              end else begin
                rsp_valid_d = 1'b0;
                ram_addr_d  = sp_below;
                state_d     = RD;
              end
            end
            default: rsp_error_d = 1'b1;
          endcase
        end
      end

      // RAM samples the held address at the end of this cycle.
      RD: state_d = WB;

      WB: begin
        case (op_q)
          OP_SWAP: begin
            top_d       = ram_rdata;
            ram_we_d    = 1'b1;
            ram_wdata_d = top_q;
            state_d     = SWR;
          end
          OP_ADD: begin
            top_d       = top_q + ram_rdata;
            count_d     = cnt_m1;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end
          default: begin
            top_d       = ram_rdata;
            count_d     = cnt_m1;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
          end
        endcase
      end

      SWR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      top_q       <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      top_q       <= top_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign top       = top_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: queue-based reference stack, RAM model, per-cycle
// response/write checker and directed scenarios with literal expectations.
module tb_stack_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] top;
  logic [AW:0]   count;
  logic          empty, full;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 CLK = ~CLK;

  stack_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_error(rsp_error), .top(top), .count(count), .empty(empty),
    .full(full), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [DW-1:0] mem [0:255];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else        ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int due; bit err; logic [DW-1:0] etop; int ecnt; } rsp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  rsp_t          rq[$];
  wr_t           wq[$];
  logic [DW-1:0] stk[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string detail);
    checks++;
    failures++;
    $display("FAIL %s: %s", nm, detail);
  endtask

  // Reference: apply the command to the abstract stack and queue the
  // response (and any RAM spill) it must produce.
  task automatic model_apply(input int op, input logic [DW-1:0] d);
    rsp_t r;
    wr_t w;
    logic [DW-1:0] a, b;
    int lat = 1;
    int n = stk.size();
    r.err = 1'b0;
    case (op)
      0: ;
      1: if (n == DEPTH) r.err = 1'b1;
         else begin
           if (n > 0) begin w.a = AW'(n - 1); w.d = stk[n-1]; wq.push_back(w); end
           stk.push_back(d);
         end
      2: if (n == 0) r.err = 1'b1;
         else begin lat = (n == 1) ? 1 : 3; a = stk.pop_back(); end
      3: if (n == 0) r.err = 1'b1;
         else stk[n-1] = stk[n-1] + 1;
      4: if (n < 2) r.err = 1'b1;
         else begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a + b); lat = 3; end
      5: if (n < 2) r.err = 1'b1;
         else begin
           w.a = AW'(n - 2); w.d = stk[n-1]; wq.push_back(w);
           a = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = a; lat = 4;
         end
      default: r.err = 1'b1;
    endcase
    r.due  = cyc + lat;
    r.ecnt = stk.size();
    r.etop = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    rq.push_back(r);
  endtask

  always @(negedge CLK) begin : compare
    rsp_t r;
    wr_t w;
    if (!RST) begin
      chk("err_qualified", {63'd0, rsp_error & ~rsp_valid}, 64'd0);
      if (rsp_valid) begin
        if (rq.size() == 0) fail("rsp_unexpected", "got rsp_valid=1 expected 0");
        else begin
          r = rq.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(r.due));
          chk("rsp_error", {63'd0, rsp_error}, {63'd0, r.err});
          chk("top", 64'(top), 64'(r.etop));
          chk("count", 64'(count), 64'(r.ecnt));
          chk("empty", {63'd0, empty}, {63'd0, r.ecnt == 0});
          chk("full", {63'd0, full}, {63'd0, r.ecnt == DEPTH});
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        fail("rsp_missing", $sformatf("got rsp_valid=0 expected 1 at cycle %0d", rq[0].due));
        void'(rq.pop_front());
      end
      if (ram_we) begin
        if (wq.size() == 0) fail("ram_we_unexpected", "got ram_we=1 expected 0");
        else begin
          w = wq.pop_front();
          chk("ram_addr", 64'(ram_addr), 64'(w.a));
          chk("ram_wdata", 64'(ram_wdata), 64'(w.d));
        end
      end
    end
  end

  task automatic do_reset(input int edges);
    RST = 1'b1;
    cmd_valid = 1'b0;
    rq.delete(); wq.delete(); stk.delete();
    repeat (edges) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic send(input int op, input logic [DW-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 40) begin @(negedge CLK); n++; end
    if (!cmd_ready) begin fail("ready_timeout", "got cmd_ready=0 expected 1"); return; end
    cmd_valid = 1'b1; cmd_op = 3'(op); cmd_data = d;
    model_apply(op, d);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rq.size() > 0 && n < 30) begin @(negedge CLK); n++; end
    if (rq.size() > 0) fail("drain_timeout", "got pending response expected none");
    @(negedge CLK);
  endtask

  initial begin
    do_reset(2);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_top", 64'(top), 64'd0);
    chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("rst_we", {63'd0, ram_we}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);

    send(1, 3); send(1, 4); send(4, 0); drain();
    chk("add_top", 64'(top), 64'd7);
    chk("add_count", 64'(count), 64'd1);
    chk("add_mem0", 64'(mem[0]), 64'd3);

    do_reset(1);
    send(2, 0); send(3, 0); send(4, 0); send(5, 0); send(6, 0); send(7, 0); send(0, 0);
    drain();
    chk("err_count", 64'(count), 64'd0);

    do_reset(1);
    send(1, 32'hFFFF_FFFF); send(3, 0); drain();
    chk("inc_wrap_top", 64'(top), 64'd0);
    chk("inc_wrap_count", 64'(count), 64'd1);
    do_reset(1);
    send(1, 32'hFFFF_FFFF); send(1, 32'hFFFF_FFFF); send(4, 0); drain();
    chk("add_wrap_top", 64'(top), 64'hFFFF_FFFE);

    do_reset(1);
    send(1, 1); send(1, 2); send(5, 0); drain();
    chk("swap_top", 64'(top), 64'd1);
    chk("swap_mem0", 64'(mem[0]), 64'd2);
    chk("swap_count", 64'(count), 64'd2);
    send(2, 0); drain();
    chk("pop_top", 64'(top), 64'd2);
    chk("pop_count", 64'(count), 64'd1);

    // A command held valid while the controller is busy must not be taken.
    send(1, 10); send(2, 0);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 32'd77;
    @(negedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    drain();
    chk("busy_ignored_count", 64'(count), 64'd1);

    send(1, 5); send(3, 0); send(5, 0); send(1, 9); send(0, 0); send(4, 0); send(2, 0);
    drain();

    do_reset(1);
    for (int i = 1; i <= DEPTH; i++) send(1, DW'(i));
    drain();
    chk("fill_full", {63'd0, full}, 64'd1);
    chk("fill_count", 64'(count), 64'(DEPTH));
    send(1, 999); drain();
    send(2, 0); drain();
    chk("first_pop_top", 64'(top), 64'(DEPTH - 1));
    for (int i = 1; i < DEPTH; i++) send(2, 0);
    drain();
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_top", 64'(top), 64'd0);

    do_reset(1);
    send(1, 5); send(1, 6); drain();
    send(2, 0);
    RST = 1'b1;
    rq.delete(); wq.delete(); stk.delete();
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_ready", {63'd0, cmd_ready}, 64'd1);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_top", 64'(top), 64'd0);
    chk("midrst_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_we", {63'd0, ram_we}, 64'd0);
    @(negedge CLK);
    chk("midrst_rsp_late", {63'd0, rsp_valid}, 64'd0);

    chk("writes_outstanding", 64'(wq.size()), 64'd0);
    chk("rsps_outstanding", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
